csrwbm: RTL and testbench



---
 rtl/csrwbm.sv | 166 ++++++++++++++++
 tb/tb_csrwbm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csrwbm.sv
// rtl/csrwbm.sv - CSR-programmed single-word Wishbone master with timeout and completion irq
module csrwbm #(
    parameter logic [3:0] csr_addr  = 4'h2,
    parameter int         timeout_w = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t               state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 we_q, we_d;
    logic                 ainc_q, ainc_d;
    logic                 irq_en_q, irq_en_d;
    logic [3:0]           sel_q, sel_d;
    logic [timeout_w-1:0] timeout_q, timeout_d;
    logic [timeout_w-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic [31:0]          csr_do_q, csr_do_d;

    logic        page_hit;
    logic        csr_wr;
    logic [2:0]  idx;
    logic [31:0] rd_val;

    always_comb begin
        page_hit  = (csr_a[13:10] == csr_addr);
        csr_wr    = page_hit && csr_we;
        idx       = csr_a[2:0];

        state_d   = state_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        ainc_d    = ainc_q;
        irq_en_d  = irq_en_q;
        sel_d     = sel_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        tmo_d     = tmo_q;

        // w1c is applied first so a completion in the same cycle overrides it
        if (csr_wr && idx == 3'd4) begin
            if (csr_di[1]) done_d = 1'b0;
            if (csr_di[2]) tmo_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (csr_wr) begin
                    case (idx)
                        3'd0: adr_d = {csr_di[31:2], 2'b00};
                        3'd1: wdata_d = csr_di;
                        3'd3: begin
                            we_d     = csr_di[1];
                            ainc_d   = csr_di[2];
                            irq_en_d = csr_di[3];
                            sel_d    = csr_di[7:4];
                            if (csr_di[0]) begin
                                state_d = S_BUS;
                                done_d  = 1'b0;
                                tmo_d   = 1'b0;
                                cnt_d   = timeout_q;
                            end
                        end
                        3'd5: timeout_d = csr_di[timeout_w-1:0];
                        default: ;
                    endcase
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    tmo_d   = 1'b0;
                    if (!we_q) rdata_d = wbm_dat_i;
                    if (ainc_q) adr_d = adr_q + 32'd4;
                end else if (timeout_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(timeout_w-1){1'b0}}, 1'b1}) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (idx)
            3'd0:    rd_val = adr_q;
            3'd1:    rd_val = wdata_q;
            3'd2:    rd_val = rdata_q;
            3'd3:    rd_val = {24'd0, sel_q, irq_en_q, ainc_q, we_q, 1'b0};
            3'd4:    rd_val = {29'd0, tmo_q, done_q, state_q == S_BUS};
            3'd5:    rd_val = 32'(timeout_q);
            default: rd_val = 32'd0;
        endcase
        // zero when unselected: all CSR slaves' read data are ORed together
        csr_do_d = page_hit ? rd_val : 32'd0;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            adr_q     <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            we_q      <= 1'b0;
            ainc_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            sel_q     <= 4'd0;
            timeout_q <= '1;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            csr_do_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            ainc_q    <= ainc_d;
            irq_en_q  <= irq_en_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            csr_do_q  <= csr_do_d;
        end
    end

    assign csr_do    = csr_do_q;
    assign irq       = done_q & irq_en_q;
    assign wbm_cyc_o = (state_q == S_BUS);
    assign wbm_stb_o = (state_q == S_BUS);
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdata_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cti_o = 3'b000;

endmodule

// File: tb/tb_csrwbm.sv
// tb/tb_csrwbm.sv - randomized self-checking bench for csrwbm against a transaction-level model
module tb_csrwbm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
    logic [2:0]  wbm_cti_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    csrwbm dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
        .irq(irq),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cti_o(wbm_cti_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
    );

    // transaction-level model of the programmer-visible state
    logic [31:0] m_adr, m_wdata, m_rdata;
    logic [15:0] m_to;
    logic        m_we, m_ainc, m_ie, m_done, m_tmo;
    logic [3:0]  m_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_adr = 0; m_wdata = 0; m_rdata = 0; m_to = 16'hFFFF;
        m_we = 0; m_ainc = 0; m_ie = 0; m_sel = 0; m_done = 0; m_tmo = 0;
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d);
        case (idx)
            3'd0: m_adr = d & 32'hFFFF_FFFC;
            3'd1: m_wdata = d;
            3'd3: begin
                m_we = d[1]; m_ainc = d[2]; m_ie = d[3]; m_sel = d[7:4];
                if (d[0]) begin m_done = 0; m_tmo = 0; end
            end
            3'd4: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_tmo = 0;
            end
            3'd5: m_to = d[15:0];
            default: ;
        endcase
    endtask

    task automatic csr_wr_now(input logic [2:0] idx, input logic [31:0] d);
        csr_a = {4'h2, 7'd0, idx}; csr_di = d; csr_we = 1'b1;
        @(posedge clk); #1 csr_we = 1'b0;
        model_write(idx, d);
    endtask

    task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
        @(negedge clk);
        csr_wr_now(idx, d);
    endtask

    task automatic csr_rd_raw(input logic [13:0] a, output logic [31:0] v);
        @(negedge clk); csr_a = a; csr_we = 1'b0;
        @(posedge clk);
        @(negedge clk); v = csr_do;
    endtask

    task automatic csr_rd(input logic [2:0] idx, output logic [31:0] v);
        csr_rd_raw({4'h2, 7'd0, idx}, v);
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        csr_rd(3'd0, v); check({tag, "_adr"}, v, m_adr);
        csr_rd(3'd1, v); check({tag, "_wdata"}, v, m_wdata);
        csr_rd(3'd2, v); check({tag, "_rdata"}, v, m_rdata);
        csr_rd(3'd3, v); check({tag, "_ctrl"}, v, {24'd0, m_sel, m_ie, m_ainc, m_we, 1'b0});
        csr_rd(3'd4, v); check({tag, "_status"}, v, {29'd0, m_tmo, m_done, 1'b0});
        csr_rd(3'd5, v); check({tag, "_timeout"}, v, {16'd0, m_to});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_done & m_ie});
    endtask

    // slave raises ack during the ack_at-th cycle of cyc (0 = never); returns cyc length
    task automatic bus_run(input int ack_at, input logic [31:0] rd, input bit w1c, output int cycles);
        bit fin = 0;
        int k = 0;
        cycles = 0;
        while (!fin && k < 64) begin
            @(negedge clk);
            k++;
            if (!wbm_cyc_o) begin
                fin = 1;
            end else begin
                cycles++;
                check("wb_adr", wbm_adr_o, m_adr);
                check("wb_dat", wbm_dat_o, m_wdata);
                check("wb_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, {27'd0, m_we, m_sel});
                check("wb_stb_cti", {28'd0, wbm_stb_o, wbm_cti_o}, 32'h8);
                if (cycles == ack_at) begin
                    wbm_ack_i = 1'b1; wbm_dat_i = rd;
                    if (w1c) begin
                        csr_a = {4'h2, 7'd0, 3'd4}; csr_di = 32'h2; csr_we = 1'b1;
                    end
                end
                @(posedge clk); #1 wbm_ack_i = 1'b0; csr_we = 1'b0;
            end
        end
        if (!fin) check("bus_budget", 32'd0, 32'd1);
    endtask

    // outcome of one transfer from the rules: ack wins over a simultaneous timeout
    task automatic model_finish(input int ack_at, input logic [31:0] rd, output int exp_cycles);
        if (ack_at != 0 && (m_to == 0 || ack_at <= int'(m_to))) begin
            m_done = 1; m_tmo = 0;
            if (!m_we) m_rdata = rd;
            if (m_ainc) m_adr = m_adr + 32'd4;
            exp_cycles = ack_at;
        end else begin
            m_done = 1; m_tmo = 1;
            exp_cycles = int'(m_to);
        end
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [31:0] ctrl, input logic [15:0] to, input int ack_at,
                           input logic [31:0] rd, input bit w1c);
        int cyc_n, exp_n;
        csr_wr(3'd0, adr);
        csr_wr(3'd1, wd);
        csr_wr(3'd5, {16'd0, to});
        csr_wr(3'd3, ctrl);
        bus_run(ack_at, rd, w1c, cyc_n);
        model_finish(ack_at, rd, exp_n);
        check({tag, "_cycles"}, cyc_n, exp_n);
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] v;
        int n, exp_n, idle_cyc;
        rst_n = 1'b0; csr_a = 0; csr_we = 0; csr_di = 0; wbm_dat_i = 0; wbm_ack_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o[24:0]}, 32'd0);
        check("rst_dat_o", wbm_dat_o, 32'd0);
        check("rst_csr_do", csr_do, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        check_regs("rst");

        do_xfer("read", 32'h4000_0010, 32'h0, 32'h0F1, 16'hFFFF, 4, 32'hDEAD_BEEF, 0);
        csr_rd(3'd2, v); check("read_rdata_lit", v, 32'hDEAD_BEEF);
        csr_rd(3'd4, v); check("read_status_lit", v, 32'h2);

        do_xfer("wr_ainc", 32'h4000_0000, 32'h1234_5678, 32'h037, 16'hFFFF, 2, 32'h0, 0);
        csr_rd(3'd0, v); check("wr_ainc_adr_lit", v, 32'h4000_0004);

        do_xfer("tmo", 32'h100, 32'h0, 32'h0F9, 16'd5, 0, 32'h0, 0);
        csr_rd(3'd4, v); check("tmo_status_lit", v, 32'h6);
        check("tmo_irq_lit", {31'd0, irq}, 32'd1);
        csr_wr(3'd4, 32'h6);
        check("tmo_irq_clr", {31'd0, irq}, 32'd0);

        // busy lockout: stalled read, then attempts to rewrite ADR and restart
        csr_wr(3'd5, 32'd0);
        csr_wr(3'd0, 32'h200);
        csr_wr(3'd3, 32'h0F1);
        @(negedge clk); csr_a = {4'h2, 7'd0, 3'd0}; csr_di = 32'h1234; csr_we = 1'b1;
        @(posedge clk); #1 csr_we = 1'b0;
        @(negedge clk); csr_a = {4'h2, 7'd0, 3'd3}; csr_di = 32'h0A3; csr_we = 1'b1;
        @(posedge clk); #1 csr_we = 1'b0;
        csr_rd(3'd4, v); check("busy_status", v & 32'h1, 32'h1);
        csr_rd(3'd0, v); check("busy_adr", v, 32'h200);
        bus_run(2, 32'h5555_AAAA, 0, n);
        check("busy_ack_seen", {31'd0, n == 2}, 32'd1);
        model_finish(2, 32'h5555_AAAA, exp_n);
        idle_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wbm_cyc_o) idle_cyc++;
        end
        check("busy_one_cycle", idle_cyc, 0);
        check_regs("busy");

        do_xfer("race_tmo", 32'h300, 32'h0, 32'h0F1, 16'd4, 4, 32'hA5A5_0F0F, 0);
        do_xfer("race_w1c", 32'h304, 32'h0, 32'h0F9, 16'd0, 3, 32'h0BAD_F00D, 1);

        // back-to-back: restart in the first idle cycle after completion
        csr_wr(3'd3, 32'h0F1);
        bus_run(2, 32'h1111_2222, 0, n);
        model_finish(2, 32'h1111_2222, exp_n);
        csr_wr_now(3'd3, 32'h0F3);
        bus_run(2, 32'h0, 0, n);
        model_finish(2, 32'h0, exp_n);
        check("b2b_cycles", n, exp_n);
        check_regs("b2b");

        for (int it = 0; it < 40; it++) begin
            logic [31:0] ra, rw, rc, rd;
            int to, ack;
            ra = $urandom; rw = $urandom; rd = $urandom;
            rc = {24'd0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1};
            to = $urandom_range(0, 8);
            ack = $urandom_range(0, 9);
            if (ack == 1) ack = 2;
            if (to == 0 && ack == 0) ack = 3;
            do_xfer("rand", ra, rw, rc, 16'(to), ack, rd, ($urandom_range(0, 3) == 0));
        end

        // reset in the middle of a bus cycle
        csr_wr(3'd5, 32'd0);
        csr_wr(3'd3, 32'h0F9);
        @(negedge clk);
        check("rst_mid_busy", {31'd0, wbm_cyc_o}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        check_regs("rst_mid");

        csr_wr(3'd0, 32'hCAFE_0000);
        csr_rd_raw({4'h3, 7'd0, 3'd0}, v); check("iso_page", v, 32'd0);
        csr_rd(3'd6, v); check("reg6", v, 32'd0);
        csr_rd(3'd7, v); check("reg7", v, 32'd0);
        csr_rd(3'd0, v); check("iso_adr", v, m_adr);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
